branch_predictor_btb: RTL

- Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core.
- Supplies the next fetch PC in Fetch, carries its prediction to Decode in lockstep with the F/D pipeline register, and flags mispredicts against the branch resolved in Decode.
- Replaces the fixed PC+4 / PCBranchD selection in front of the PC register.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_pipreg_fd.sv | 53 +++++
 rtl/branch_predictor_btb.sv | 105 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB branch predictor: 2-bit direction
// counter encoding, saturating counter update and default geometry.
package bp_pkg;

  typedef logic [1:0] bp_cnt_t;

  localparam bp_cnt_t CNT_SNT = 2'b00;
  localparam bp_cnt_t CNT_WNT = 2'b01;
  localparam bp_cnt_t CNT_WT  = 2'b10;
  localparam bp_cnt_t CNT_ST  = 2'b11;

  localparam int BP_WIDTH_DEF   = 32;
  localparam int BP_ENTRIES_DEF = 16;

  // Counts toward strongly-taken on taken, toward strongly-not-taken otherwise;
  // never wraps at either end.
  function automatic bp_cnt_t sat_update(input bp_cnt_t cnt, input logic taken);
    bp_cnt_t res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = cnt + 2'b01;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_pipreg_fd.sv
// F->D prediction pipeline register. FlushD clears, StallD holds, else captures.
// Flush takes priority over stall.
module bp_pipreg_fd #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             pred_taken_f_i,
  input  logic [WIDTH-1:0] pred_pc_f_i,
  input  logic [WIDTH-1:0] pc_f_i,
  output logic             pred_taken_d_o,
  output logic [WIDTH-1:0] pred_pc_d_o,
  output logic [WIDTH-1:0] pc_d_o
);

  logic             pred_taken_q, pred_taken_d;
  logic [WIDTH-1:0] pred_pc_q, pred_pc_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pred_taken_d = pred_taken_q;
    pred_pc_d    = pred_pc_q;
    pc_d         = pc_q;
    if (FlushD) begin
      pred_taken_d = 1'b0;
      pred_pc_d    = '0;
      pc_d         = '0;
    end else if (!StallD) begin
      pred_taken_d = pred_taken_f_i;
      pred_pc_d    = pred_pc_f_i;
      pc_d         = pc_f_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_taken_q <= 1'b0;
      pred_pc_q    <= '0;
      pc_q         <= '0;
    end else begin
      pred_taken_q <= pred_taken_d;
      pred_pc_q    <= pred_pc_d;
      pc_q         <= pc_d;
    end
  end

  assign pred_taken_d_o = pred_taken_q;
  assign pred_pc_d_o    = pred_pc_q;
  assign pc_d_o         = pc_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: predicts the next fetch PC,
// carries the prediction into Decode and flags mispredicts there.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int WIDTH   = BP_WIDTH_DEF,
  parameter int ENTRIES = BP_ENTRIES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] PCF,
  output logic             HitF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredPCF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             BranchD,
  input  logic             ActualTakenD,
  input  logic [WIDTH-1:0] ActualTargetD,
  input  logic [WIDTH-1:0] PCPlus4D,
  output logic             MispredictD,
  output logic [WIDTH-1:0] RedirectPCD
);

  localparam int IDXB = $clog2(ENTRIES);
  localparam int TAGB = WIDTH - IDXB - 2;
  localparam logic [WIDTH-1:0] PC_STEP = 4;

  typedef struct packed {
    logic             valid;
    logic [TAGB-1:0]  tag;
    logic [WIDTH-1:0] target;
    bp_cnt_t          cnt;
  } btb_entry_t;

  btb_entry_t tbl_q [ENTRIES];
  btb_entry_t tbl_d [ENTRIES];

  logic [IDXB-1:0]  idx_f, idx_d;
  logic [TAGB-1:0]  tag_f, tag_d;
  btb_entry_t       ent_f, ent_d;
  logic             hit_d;
  logic             PredTakenD;
  logic [WIDTH-1:0] PredPCD, PCD, CorrectPCD;
  logic             unused_pcd_lo;

  // Fetch-side lookup reads registered table contents only, so an update in
  // the same cycle becomes visible on the following cycle.
  assign idx_f      = PCF[IDXB+1:2];
  assign tag_f      = PCF[WIDTH-1:IDXB+2];
  assign ent_f      = tbl_q[idx_f];
  assign HitF       = ent_f.valid && (ent_f.tag == tag_f);
  assign PredTakenF = HitF && ent_f.cnt[1];
  assign PredPCF    = PredTakenF ? ent_f.target : (PCF + PC_STEP);

  bp_pipreg_fd #(.WIDTH(WIDTH)) u_pipreg_fd (
    .clk            (clk),
    .reset          (reset),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .pred_taken_f_i (PredTakenF),
    .pred_pc_f_i    (PredPCF),
    .pc_f_i         (PCF),
    .pred_taken_d_o (PredTakenD),
    .pred_pc_d_o    (PredPCD),
    .pc_d_o         (PCD)
  );

  assign idx_d         = PCD[IDXB+1:2];
  assign tag_d         = PCD[WIDTH-1:IDXB+2];
  assign unused_pcd_lo = ^PCD[1:0];
  assign ent_d         = tbl_q[idx_d];
  assign hit_d         = ent_d.valid && (ent_d.tag == tag_d);

  assign CorrectPCD  = (BranchD && ActualTakenD) ? ActualTargetD : PCPlus4D;
  assign RedirectPCD = CorrectPCD;
  assign MispredictD = (BranchD || PredTakenD) && (PredPCD != CorrectPCD);

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) tbl_d[i] = tbl_q[i];
    if (!StallD && !FlushD) begin
      if (BranchD) begin
        if (hit_d) begin
          tbl_d[idx_d].cnt = sat_update(ent_d.cnt, ActualTakenD);
          if (ActualTakenD) tbl_d[idx_d].target = ActualTargetD;
        end else if (ActualTakenD) begin
          tbl_d[idx_d] = '{valid: 1'b1, tag: tag_d, target: ActualTargetD, cnt: CNT_WT};
        end
      end else if (PredTakenD) begin
        // Predicted taken on something that is not a branch: drop the entry.
        tbl_d[idx_d].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
    end else begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
    end
  end

endmodule
